// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the instruction fetch path: fetch FSM states, reset PC default and
// the instruction-format view used by the downstream decoder.
package instr_fetch_unit_pkg;

   localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_REQ,
      FETCH_WAIT,
      DRAIN
   } fetch_state_e;

   typedef enum logic [2:0] {
      InstrR,
      InstrI,
      InstrS,
      InstrB,
      InstrU,
      InstrJ,
      InstrIllegal
   } instr_type_enum;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } fields_instr;

   function automatic instr_type_enum instr_type(input logic [6:0] opcode);
      case (opcode)
         7'b0110011:                         return InstrR;
         7'b0010011, 7'b0000011, 7'b1100111: return InstrI;
         7'b0100011:                         return InstrS;
         7'b1100011:                         return InstrB;
         7'b0110111, 7'b0010111:             return InstrU;
         7'b1101111:                         return InstrJ;
         default:                            return InstrIllegal;
      endcase
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two instruction queue with synchronous flush; push and pop may coincide
// when full, leaving occupancy unchanged.
module fetch_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 64,
   localparam int unsigned AddrW = $clog2(Depth),
   localparam int unsigned CntW  = AddrW + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [Width-1:0] push_data_i,
   input  logic             pop_i,
   output logic [Width-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o     = (cnt_q == CntW'(Depth));
   assign empty_o    = (cnt_q == '0);
   assign count_o    = cnt_q;
   assign pop_data_o = mem_q[rptr_q];
   assign do_pop     = pop_i && !empty_o;
   assign do_push    = push_i && (!full_o || pop_i);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + AddrW'(1);
         if (do_pop)  rptr_d = rptr_q + AddrW'(1);
         cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wptr_q] <= push_data_i;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetcher: issues word fetches, queues responses with
// their PCs for the decoder, and squashes in-flight work on redirect.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DefaultResetPc,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] Instr,
   output logic [31:0] instr_pc
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  req_addr_q, req_addr_d;
   logic [31:0]  redirect_pc_aligned;
   logic         push, pop, empty;
   logic         unused_full;
   logic [1:0]   unused_rpc_lsbs;
   logic [CntW-1:0] count;
   logic [63:0]  push_data, head;

   assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};
   assign unused_rpc_lsbs     = redirect_pc[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FETCH_REQ;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      unique case (state_q)
         FETCH_REQ: begin
            if (imem_req && imem_gnt) begin
               req_addr_d = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = redirect_valid ? DRAIN : FETCH_WAIT;
            end
         end
         FETCH_WAIT: begin
            if (redirect_valid) state_d = imem_rvalid ? FETCH_REQ : DRAIN;
            else if (imem_rvalid) state_d = FETCH_REQ;
         end
         // A redirect here still waits for the stale response, unless it lands this cycle.
         DRAIN: begin
            if (imem_rvalid) state_d = FETCH_REQ;
         end
         default: state_d = FETCH_REQ;
      endcase
      if (redirect_valid) fetch_pc_d = redirect_pc_aligned;
   end

   // No response is outstanding in FETCH_REQ, so occupancy alone bounds the queue.
   always_comb begin
      imem_req    = (state_q == FETCH_REQ) && (count < CntW'(FIFO_DEPTH)) && !rst;
      imem_addr   = fetch_pc_q;
      push        = (state_q == FETCH_WAIT) && imem_rvalid && !redirect_valid;
      push_data   = {imem_rdata, req_addr_q};
      instr_valid = !empty;
      Instr       = empty ? 32'h0 : head[63:32];
      instr_pc    = empty ? 32'h0 : head[31:0];
      pop         = instr_valid && instr_ready;
   end

   fetch_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (64)
   ) u_fetch_fifo (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (redirect_valid),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .pop_data_o  (head),
      .full_o      (unused_full),
      .empty_o     (empty),
      .count_o     (count)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle table for streaming/backpressure, then
// hand-written redirect, wrap and reset sequences.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt, imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid, instr_ready;
   logic [31:0] Instr, instr_pc;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .Instr          (Instr),
      .instr_pc       (instr_pc)
   );

   typedef struct {
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        ready;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later.
   task automatic drive(input logic g, input logic r, input logic [31:0] d, input logic rdy,
                        input logic rd, input logic [31:0] rp);
      @(negedge clk);
      imem_gnt       = g;
      imem_rvalid    = r;
      imem_rdata     = d;
      instr_ready    = rdy;
      redirect_valid = rd;
      redirect_pc    = rp;
      #1;
   endtask

   task automatic chk_instr(input string name, input logic [31:0] ins, input logic [31:0] pc);
      chk({name, "_valid"}, {31'h0, instr_valid}, 32'h1);
      chk({name, "_instr"}, Instr, ins);
      chk({name, "_pc"}, instr_pc, pc);
   endtask

   initial begin
      //         gnt  rv  rdata         rdy  req  addr      vld  instr         pc
      tbl[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00, 1'b0, 32'h0,        32'h0};
      tbl[1]  = '{1'b1, 1'b1, 32'hA000_0000, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0,        32'h0};
      tbl[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h04, 1'b1, 32'hA000_0000, 32'h0};
      tbl[3]  = '{1'b1, 1'b1, 32'hA000_0004, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0,        32'h0};
      tbl[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h08, 1'b1, 32'hA000_0004, 32'h4};
      tbl[5]  = '{1'b1, 1'b1, 32'hA000_0008, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0,        32'h0};
      tbl[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0C, 1'b1, 32'hA000_0008, 32'h8};
      tbl[7]  = '{1'b1, 1'b1, 32'hA000_000C, 1'b0, 1'b0, 32'h00, 1'b1, 32'hA000_0008, 32'h8};
      tbl[8]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00, 1'b1, 32'hA000_0008, 32'h8};
      tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00, 1'b1, 32'hA000_0008, 32'h8};
      tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00, 1'b1, 32'hA000_0008, 32'h8};
      tbl[11] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h10, 1'b1, 32'hA000_000C, 32'hC};
      tbl[12] = '{1'b0, 1'b1, 32'hA000_0010, 1'b1, 1'b0, 32'h00, 1'b1, 32'hA000_000C, 32'hC};
      tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h14, 1'b1, 32'hA000_0010, 32'h10};
      tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h14, 1'b0, 32'h0,        32'h0};

      rst = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_instr", Instr, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      rst = 1'b0;
      #1;
      chk("first_req", {31'h0, imem_req}, 32'h1);
      chk("first_addr", imem_addr, 32'h0);

      // Streaming, then backpressure filling both queue entries.
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].ready, 1'b0, 32'h0);
         chk($sformatf("row%0d_req", i), {31'h0, imem_req}, {31'h0, tbl[i].exp_req});
         if (tbl[i].exp_req)
            chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].exp_addr);
         chk($sformatf("row%0d_valid", i), {31'h0, instr_valid}, {31'h0, tbl[i].exp_valid});
         if (tbl[i].exp_valid) begin
            chk($sformatf("row%0d_instr", i), Instr, tbl[i].exp_instr);
            chk($sformatf("row%0d_ipc", i), instr_pc, tbl[i].exp_pc);
         end
      end

      // Redirect in FETCH_WAIT without rvalid: drain the stale response.
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("c1_addr", imem_addr, 32'h14);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_1003);
      chk("c2_req", {31'h0, imem_req}, 32'h0);
      drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
      chk("c3_req", {31'h0, imem_req}, 32'h0);
      chk("c3_valid", {31'h0, instr_valid}, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("c4_req", {31'h0, imem_req}, 32'h1);
      chk("c4_addr", imem_addr, 32'h0000_1000);
      chk("c4_valid", {31'h0, instr_valid}, 32'h0);
      drive(1'b0, 1'b1, 32'hC000_1000, 1'b0, 1'b0, 32'h0);
      chk("c5_valid", {31'h0, instr_valid}, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk_instr("c6", 32'hC000_1000, 32'h0000_1000);
      chk("c6_addr", imem_addr, 32'h0000_1004);
      drive(1'b0, 1'b1, 32'hC000_1004, 1'b0, 1'b0, 32'h0);

      // Redirect coincident with gnt while an entry is queued.
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_2000);
      chk("c8_req", {31'h0, imem_req}, 32'h1);
      chk("c8_addr", imem_addr, 32'h0000_1008);
      chk_instr("c8", 32'hC000_1004, 32'h0000_1004);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_3000);
      chk("c9_valid", {31'h0, instr_valid}, 32'h0);
      chk("c9_req", {31'h0, imem_req}, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("c10_req", {31'h0, imem_req}, 32'h0);
      drive(1'b0, 1'b1, 32'hBADB_AD01, 1'b1, 1'b0, 32'h0);
      chk("c11_valid", {31'h0, instr_valid}, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("c12_req", {31'h0, imem_req}, 32'h1);
      chk("c12_addr", imem_addr, 32'h0000_3000);
      chk("c12_valid", {31'h0, instr_valid}, 32'h0);

      // Redirect coincident with rvalid, to the top word for the wrap check.
      drive(1'b0, 1'b1, 32'hBADB_AD02, 1'b1, 1'b1, 32'hFFFF_FFFC);
      chk("c13_req", {31'h0, imem_req}, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("c14_valid", {31'h0, instr_valid}, 32'h0);
      chk("c14_req", {31'h0, imem_req}, 32'h1);
      chk("c14_addr", imem_addr, 32'hFFFF_FFFC);
      drive(1'b0, 1'b1, 32'hD000_0000, 1'b1, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk_instr("c16", 32'hD000_0000, 32'hFFFF_FFFC);
      chk("c16_addr", imem_addr, 32'h0000_0000);

      // Reset while waiting for a response; a stale rvalid afterwards is ignored.
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("c17_req", {31'h0, imem_req}, 32'h0);
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("c18_req", {31'h0, imem_req}, 32'h0);
      chk("c18_valid", {31'h0, instr_valid}, 32'h0);
      chk("c18_instr", Instr, 32'h0);
      chk("c18_pc", instr_pc, 32'h0);
      rst = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hEEEE_0004;
      #1;
      chk("c18_restart_req", {31'h0, imem_req}, 32'h1);
      chk("c18_restart_addr", imem_addr, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("c19_valid", {31'h0, instr_valid}, 32'h0);
      chk("c19_req", {31'h0, imem_req}, 32'h1);
      chk("c19_addr", imem_addr, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2: instruction queue entries (power of two, >= 2).
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 imem_req  output  1: fetch request valid.
REQ-006 imem_addr  output  32: word-aligned fetch address.
REQ-007 imem_gnt  input  1: memory accepts the request this cycle.
REQ-008 imem_rvalid  input  1: response data valid.
REQ-009 imem_rdata  input  32: fetched instruction word.
REQ-010 redirect_valid  input  1: branch/jump redirect strobe.
REQ-011 redirect_pc  input  32: new fetch address; bits [1:0] forced to 0.
REQ-012 instr_valid  output  1: Instr available to decoder.
REQ-013 instr_ready  input  1: decoder accepts Instr.
REQ-014 Instr  output  32: instruction word feeding the format decoder.
REQ-015 instr_pc  output  32: address of Instr.

Function
REQ-016 FSM states FETCH_REQ, FETCH_WAIT, DRAIN.
REQ-017 FETCH_REQ: imem_req=1 when queue free slots >= 1; imem_addr=fetch_pc; on imem_gnt go FETCH_WAIT, fetch_pc <= fetch_pc+4.
REQ-018 imem_req and imem_addr SHALL hold stable while waiting for imem_gnt, except on redirect.
REQ-019 At most one outstanding request; imem_req=0 in FETCH_WAIT and DRAIN.
REQ-020 FETCH_WAIT: on imem_rvalid push {imem_rdata, request address} into queue, return to FETCH_REQ.
REQ-021 Response latency >= 1 cycle after gnt; imem_rvalid outside FETCH_WAIT/DRAIN is ignored.
REQ-022 Queue output drives Instr/instr_pc/instr_valid combinationally from the head entry; pop when instr_valid && instr_ready.
REQ-023 Simultaneous push and pop on a full queue is legal; occupancy unchanged.
REQ-024 Request issued only if occupancy < FIFO_DEPTH counting the outstanding response, so a response never overflows.
REQ-025 Instr/instr_pc SHALL hold stable while instr_valid && !instr_ready.
REQ-026 Redirect (any state): queue flushed same edge, instr_valid=0 next cycle, fetch_pc <= {redirect_pc[31:2],2'b00}.
REQ-027 Redirect in FETCH_WAIT without same-cycle imem_rvalid: go DRAIN; the next imem_rvalid is discarded, then FETCH_REQ.
REQ-028 Redirect in FETCH_WAIT with same-cycle imem_rvalid: data discarded, go FETCH_REQ.
REQ-029 Redirect in FETCH_REQ with same-cycle imem_gnt: granted request becomes stale, go DRAIN.
REQ-030 Redirect in DRAIN: update fetch_pc, remain DRAIN.
REQ-031 Redirect has priority over pop/push in the same cycle; a pop in that cycle is still counted as accepted by the decoder.
REQ-032 fetch_pc increments modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.

Reset
REQ-033 On rst: state=FETCH_REQ, fetch_pc=RESET_PC, queue empty, imem_req=0, instr_valid=0, Instr=0, instr_pc=0.
REQ-034 First imem_req=1 in the cycle after rst deasserts.
REQ-035 rst mid-transaction drops outstanding response tracking; a post-reset stale imem_rvalid arriving while in FETCH_REQ is ignored.

Structure
REQ-036 Fetch state enum and RESET_PC default constant live in the shared package alongside instr_type_enum/fields_instr.
REQ-037 Queue is a sub-module fetch_fifo (parametric depth, 64-bit entries, flush input, full/empty/count outputs).

Verification
REQ-038 Reset then gnt=1, rvalid one cycle later, ready=1 -> imem_addr 0,4,8; Instr/instr_pc pairs match in order, one instruction per 2 cycles.
REQ-039 instr_ready=0 with FIFO_DEPTH=2 -> exactly 2 entries queued, imem_req=0 after, Instr stable; ready=1 resumes fetch.
REQ-040 Redirect to 32'h0000_1003 during FETCH_WAIT -> response discarded, next imem_addr=32'h0000_1000, no stale Instr reaches the decoder.
REQ-041 Redirect coincident with gnt and with rvalid -> DRAIN/FETCH_REQ per REQ-028/029; queue empty next cycle.
REQ-042 Redirect to 32'hFFFF_FFFC -> fetch addresses FFFF_FFFC, 0000_0000.
REQ-043 rst asserted in FETCH_WAIT -> all outputs at reset values next cycle; fetch restarts at RESET_PC.
